// File: rtl/vdg_pkg.sv
// vdg_pkg: mode encoding and per-mode row geometry (repeat count, bytes per row)
// shared by the VDG address path.
package vdg_pkg;
    localparam int ALPHA_REPEAT = 12;

    typedef enum logic [3:0] {
        ALPHA = 4'b0000,
        GM0   = 4'b1000,
        GM1   = 4'b1001,
        GM2   = 4'b1010,
        GM3   = 4'b1011,
        GM4   = 4'b1100,
        GM5   = 4'b1101,
        GM6   = 4'b1110,
        GM7   = 4'b1111
    } mode_e;

    // gm is meaningless in alpha/semigraphics, so every alpha setting folds to ALPHA
    function automatic mode_e mode_of(input logic ang, input logic [2:0] gm);
        return ang ? mode_e'({1'b1, gm}) : ALPHA;
    endfunction

    function automatic logic [3:0] mode_repeat(input logic ang, input logic [2:0] gm,
                                               input logic [3:0] alpha_rep = 4'(ALPHA_REPEAT));
        case (mode_of(ang, gm))
            GM0, GM1, GM2: return 4'd3;
            GM3, GM4:      return 4'd2;
            GM5, GM6, GM7: return 4'd1;
            default:       return alpha_rep;
        endcase
    endfunction

    function automatic logic [5:0] mode_bytes(input logic ang, input logic [2:0] gm);
        case (mode_of(ang, gm))
            GM0, GM1, GM3, GM5: return 6'd16;
            default:            return 6'd32;
        endcase
    endfunction
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registers a clk-synchronous strobe and pulses for one cycle on its
// rising (or, with FALLING set, falling) edge.
module edge_detect #(
    parameter logic RESET_VAL = 1'b0,
    parameter bit   FALLING   = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic pulse
);
    logic q;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) q <= RESET_VAL;
        else q <= d;

    assign pulse = FALLING ? (q & ~d) : (d & ~q);
endmodule

// File: rtl/video_address_gen.sv
// video_address_gen: display-memory address generator with per-mode row length
// and row repetition, driven by the frame timing strobes.
module video_address_gen #(
    parameter int ADDR_WIDTH   = 13,
    parameter int ALPHA_REPEAT = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  fsn,
    input  logic                  hsn,
    input  logic                  preload,
    input  logic                  ang,
    input  logic [2:0]            gm,
    output logic [ADDR_WIDTH-1:0] da,
    output logic [3:0]            line_in_row,
    output logic                  row_done
);
    import vdg_pkg::*;

    logic                  line_end, fetch, last_line, ang_l;
    logic [2:0]            gm_l;
    logic [3:0]            rep;
    logic [5:0]            bpr, byte_cnt;
    logic [ADDR_WIDTH-1:0] row_start;

    edge_detect #(.RESET_VAL(1'b1), .FALLING(1'b1)) u_hsn_edge (
        .clk(clk), .resetn(resetn), .d(hsn), .pulse(line_end)
    );

    edge_detect #(.RESET_VAL(1'b0), .FALLING(1'b0)) u_preload_edge (
        .clk(clk), .resetn(resetn), .d(preload), .pulse(fetch)
    );

    assign rep = mode_repeat(ang_l, gm_l, 4'(ALPHA_REPEAT));
    assign bpr = mode_bytes(ang_l, gm_l);
    // >= so that a repeat count shrinking mid-group closes the group instead of overrunning
    assign last_line = line_in_row >= rep - 4'd1;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            da          <= '0;
            row_start   <= '0;
            byte_cnt    <= '0;
            line_in_row <= '0;
            row_done    <= 1'b0;
            ang_l       <= 1'b0;
            gm_l        <= '0;
        end else begin
            row_done <= 1'b0;
            if (!fsn || line_end) begin
                ang_l <= ang;
                gm_l  <= gm;
            end
            if (!fsn) begin
                da          <= '0;
                row_start   <= '0;
                byte_cnt    <= '0;
                line_in_row <= '0;
            end else if (line_end) begin
                byte_cnt <= '0;
                if (last_line) begin
                    line_in_row <= '0;
                    row_start   <= da;
                    row_done    <= 1'b1;
                end else begin
                    line_in_row <= line_in_row + 4'd1;
                    da          <= row_start;
                end
            end else if (fetch && byte_cnt < bpr) begin
                da       <= da + ADDR_WIDTH'(1);
                byte_cnt <= byte_cnt + 6'd1;
            end
        end
endmodule
